// File: rtl/pmod_ad1_if.sv
// Pmod AD1 serial bus: chip select, serial clock and the two data lines.
// master = sampler (drives cs_n/sclk), slave = ADC (drives d0/d1).
interface pmod_ad1_if;
  logic adc_cs_n;
  logic adc_sclk;
  logic adc_d0;
  logic adc_d1;

  modport master (
    output adc_cs_n,
    output adc_sclk,
    input  adc_d0,
    input  adc_d1
  );

  modport slave (
    input  adc_cs_n,
    input  adc_sclk,
    output adc_d0,
    output adc_d1
  );
endinterface

// File: rtl/pmod_ad1_sampler.sv
// Dual-channel 12-bit SPI ADC sampler with 2^AVG_LOG2 burst averaging.
// Ports: clk, rst_n (sync, low), start, adc bus, ch0/ch1 result, valid, busy, lead_err.
module pmod_ad1_sampler #(
  parameter int CLK_DIV   = 4,
  parameter int QUIET_CYC = 8,
  parameter int AVG_LOG2  = 2,
  parameter int FREE_RUN  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  pmod_ad1_if.master  adc,
  output logic [11:0] ch0_12f0,
  output logic [11:0] ch1_12f0,
  output logic        valid,
  output logic        busy,
  output logic        lead_err
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int QW = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
  localparam int AW = 12 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);
  localparam logic GO_FREE = (FREE_RUN != 0);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    QUIET
  } state_t;

  state_t        state;
  logic [DW-1:0] div;
  logic [4:0]    h;
  logic [QW-1:0] qcnt;
  logic [CW-1:0] cnt;
  logic [14:0]   sh0;
  logic [14:0]   sh1;
  logic [15:0]   nsh0;
  logic [15:0]   nsh1;
  logic [AW-1:0] acc0;
  logic [AW-1:0] acc1;
  logic [AW-1:0] sum0;
  logic [AW-1:0] sum1;
  logic          sticky;
  logic          lead_any;
  logic          half_end;

  // The 16th bit arrives on the same edge that closes the
  // conversion, so the word is taken from the next-shift value.
  always_comb begin
    nsh0     = {sh0, adc.adc_d0};
    nsh1     = {sh1, adc.adc_d1};
    sum0     = acc0 + AW'(nsh0[11:0]);
    sum1     = acc1 + AW'(nsh1[11:0]);
    lead_any = sticky | (|nsh0[15:12]) | (|nsh1[15:12]);
    half_end = (div == DW'(CLK_DIV - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      div          <= '0;
      h            <= '0;
      qcnt         <= '0;
      cnt          <= '0;
      sh0          <= '0;
      sh1          <= '0;
      acc0         <= '0;
      acc1         <= '0;
      sticky       <= 1'b0;
      adc.adc_cs_n <= 1'b1;
      adc.adc_sclk <= 1'b1;
      ch0_12f0     <= '0;
      ch1_12f0     <= '0;
      valid        <= 1'b0;
      busy         <= 1'b0;
      lead_err     <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (GO_FREE || start) begin
            state        <= CONV;
            adc.adc_cs_n <= 1'b0;
            adc.adc_sclk <= 1'b1;
            busy         <= 1'b1;
            div          <= '0;
            h            <= '0;
          end
        end
        CONV: begin
          if (half_end) begin
            div          <= '0;
            h            <= h + 5'd1;
            adc.adc_sclk <= h[0];
            if (h[0]) begin
              sh0 <= nsh0[14:0];
              sh1 <= nsh1[14:0];
            end
            if (h == 5'd31) begin
              state        <= QUIET;
              adc.adc_cs_n <= 1'b1;
              adc.adc_sclk <= 1'b1;
              qcnt         <= '0;
              if (cnt == LAST) begin
                ch0_12f0 <= sum0[AW-1:AVG_LOG2];
                ch1_12f0 <= sum1[AW-1:AVG_LOG2];
                lead_err <= lead_any;
                valid    <= 1'b1;
                acc0     <= '0;
                acc1     <= '0;
                cnt      <= '0;
                sticky   <= 1'b0;
              end else begin
                acc0   <= sum0;
                acc1   <= sum1;
                cnt    <= cnt + CW'(1);
                sticky <= lead_any;
              end
            end
          end else begin
            div <= div + DW'(1);
          end
        end
        QUIET: begin
          if (qcnt == QW'(QUIET_CYC - 1)) begin
            // cnt != 0 means the burst still has conversions left
            if (GO_FREE || cnt != '0) begin
              state        <= CONV;
              adc.adc_cs_n <= 1'b0;
              adc.adc_sclk <= 1'b1;
              div          <= '0;
              h            <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            qcnt <= qcnt + QW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmod_ad1_sampler.sv
// Bench for pmod_ad1_sampler: three instances (single, averaging, free-run)
// against a word-level ADC model and arithmetic reference results.
module tb_pmod_ad1_sampler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0;
  logic start2 = 1'b0;
  logic startf = 1'b0;

  always #5 clk = ~clk;

  pmod_ad1_if a0 ();
  pmod_ad1_if a2 ();
  pmod_ad1_if af ();

  logic [11:0] c0_0, c1_0, c0_2, c1_2, c0_f, c1_f;
  logic v0, b0, l0, v2, b2, l2, vf, bf, lf;

  int nvec = 0;
  int nerr = 0;

  logic [15:0] q0a[$];
  logic [15:0] q0b[$];
  logic [15:0] q2a[$];
  logic [15:0] q2b[$];
  logic [15:0] s0a = '0, s0b = '0, s2a = '0, s2b = '0;
  logic [15:0] sfa = '0, sfb = '0;
  logic [15:0] wfa = '0, wfb = '0;

  pmod_ad1_sampler #(.CLK_DIV(4), .QUIET_CYC(8), .AVG_LOG2(0), .FREE_RUN(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .adc(a0),
    .ch0_12f0(c0_0), .ch1_12f0(c1_0), .valid(v0), .busy(b0), .lead_err(l0)
  );

  pmod_ad1_sampler #(.CLK_DIV(4), .QUIET_CYC(8), .AVG_LOG2(2), .FREE_RUN(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .adc(a2),
    .ch0_12f0(c0_2), .ch1_12f0(c1_2), .valid(v2), .busy(b2), .lead_err(l2)
  );

  pmod_ad1_sampler #(.CLK_DIV(4), .QUIET_CYC(8), .AVG_LOG2(0), .FREE_RUN(1)) uf (
    .clk(clk), .rst_n(rst_n), .start(startf), .adc(af),
    .ch0_12f0(c0_f), .ch1_12f0(c1_f), .valid(vf), .busy(bf), .lead_err(lf)
  );

  // ADC model: a 16-bit frame {4 leading, 12 data} loads on CS_n fall,
  // MSB is presented first and the next bit follows each SCLK rise.
  always @(negedge a0.adc_cs_n) begin
    s0a = (q0a.size() > 0) ? q0a.pop_front() : 16'h0;
    s0b = (q0b.size() > 0) ? q0b.pop_front() : 16'h0;
  end
  always @(posedge a0.adc_sclk) if (!a0.adc_cs_n) begin
    s0a = {s0a[14:0], 1'b0};
    s0b = {s0b[14:0], 1'b0};
  end
  assign a0.adc_d0 = s0a[15];
  assign a0.adc_d1 = s0b[15];

  always @(negedge a2.adc_cs_n) begin
    s2a = (q2a.size() > 0) ? q2a.pop_front() : 16'h0;
    s2b = (q2b.size() > 0) ? q2b.pop_front() : 16'h0;
  end
  always @(posedge a2.adc_sclk) if (!a2.adc_cs_n) begin
    s2a = {s2a[14:0], 1'b0};
    s2b = {s2b[14:0], 1'b0};
  end
  assign a2.adc_d0 = s2a[15];
  assign a2.adc_d1 = s2b[15];

  always @(negedge af.adc_cs_n) begin
    sfa = wfa;
    sfb = wfb;
  end
  always @(posedge af.adc_sclk) if (!af.adc_cs_n) begin
    sfa = {sfa[14:0], 1'b0};
    sfb = {sfb[14:0], 1'b0};
  end
  assign af.adc_d0 = sfa[15];
  assign af.adc_d1 = sfb[15];

  task automatic pulse0();
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
  endtask

  task automatic pulse2();
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start0 = 1'b1;
    repeat (3) @(negedge clk);
    nvec++; if (a0.adc_cs_n !== 1'b1) begin nerr++; $display("FAIL reset_cs_n got %b want 1", a0.adc_cs_n); end
    nvec++; if (a0.adc_sclk !== 1'b1) begin nerr++; $display("FAIL reset_sclk got %b want 1", a0.adc_sclk); end
    nvec++; if (c0_0 !== 12'h0 || c1_0 !== 12'h0) begin nerr++; $display("FAIL reset_ch got %h/%h want 0/0", c0_0, c1_0); end
    nvec++; if ({v0, b0, l0} !== 3'b000) begin nerr++; $display("FAIL reset_flags got %b want 000", {v0, b0, l0}); end
    start0 = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    nvec++; if (b0 !== 1'b0) begin nerr++; $display("FAIL reset_start_lost got busy %b want 0", b0); end
  endtask

  task automatic test_latency();
    int k, rises;
    logic ps, pc;
    q0a.push_back(16'h0FFF);
    q0b.push_back(16'h07FF);
    pulse0();
    k = 1;
    nvec++; if (a0.adc_cs_n !== 1'b0 || b0 !== 1'b1) begin nerr++; $display("FAIL lat_start got cs_n %b busy %b want 0 1", a0.adc_cs_n, b0); end
    rises = 0; ps = a0.adc_sclk; pc = a0.adc_cs_n;
    while (v0 !== 1'b1 && k < 400) begin
      @(negedge clk); k++;
      if (!ps && a0.adc_sclk && !pc) rises++;
      ps = a0.adc_sclk; pc = a0.adc_cs_n;
    end
    nvec++; if (k != 129) begin nerr++; $display("FAIL lat_valid got cycle %0d want 129", k); end
    nvec++; if (c0_0 !== 12'hFFF || c1_0 !== 12'h7FF) begin nerr++; $display("FAIL lat_data got %h/%h want fff/7ff", c0_0, c1_0); end
    nvec++; if (l0 !== 1'b0) begin nerr++; $display("FAIL lat_lead got %b want 0", l0); end
    nvec++; if (rises != 16) begin nerr++; $display("FAIL lat_sclk_rises got %0d want 16", rises); end
    @(negedge clk); k++;
    nvec++; if (v0 !== 1'b0) begin nerr++; $display("FAIL lat_pulse got valid %b want 0", v0); end
    while (b0 !== 1'b0 && k < 400) begin @(negedge clk); k++; end
    nvec++; if (k != 137) begin nerr++; $display("FAIL lat_busy_drop got cycle %0d want 137", k); end
  endtask

  task automatic test_random_single();
    for (int i = 0; i < 8; i++) begin
      logic [11:0] w0, w1;
      logic [3:0] ld0, ld1;
      int k;
      w0  = 12'($urandom);
      w1  = 12'($urandom);
      ld0 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      ld1 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      q0a.push_back({ld0, w0});
      q0b.push_back({ld1, w1});
      pulse0();
      k = 0;
      while (v0 !== 1'b1 && k < 400) begin @(negedge clk); k++; end
      nvec++; if (k >= 400) begin nerr++; $display("FAIL rnd1_timeout got %0d cycles want <400", k); end
      nvec++; if (c0_0 !== w0 || c1_0 !== w1) begin nerr++; $display("FAIL rnd1_data got %h/%h want %h/%h", c0_0, c1_0, w0, w1); end
      nvec++; if (l0 !== ((ld0 != 0) || (ld1 != 0))) begin nerr++; $display("FAIL rnd1_lead got %b want %b", l0, (ld0 != 0) || (ld1 != 0)); end
      while (b0 !== 1'b0 && k < 400) begin @(negedge clk); k++; end
    end
  endtask

  // Runs one queued averaging burst and checks the single result.
  task automatic run_avg(input logic [11:0] e0, input logic [11:0] e1, input logic el, input string nm);
    int k, nv, gap, ngap;
    logic [11:0] g0, g1;
    logic gl;
    pulse2();
    k = 1; nv = 0; gap = 0; ngap = 0; g0 = 'x; g1 = 'x; gl = 1'bx;
    while (b2 === 1'b1 && k < 2000) begin
      @(negedge clk); k++;
      if (v2 === 1'b1) begin nv++; g0 = c0_2; g1 = c1_2; gl = l2; end
      if (a2.adc_cs_n === 1'b1 && b2 === 1'b1) gap++;
      else if (a2.adc_cs_n === 1'b0 && gap > 0) begin
        ngap++;
        nvec++; if (gap != 8) begin nerr++; $display("FAIL %s_gap got %0d want 8", nm, gap); end
        gap = 0;
      end
    end
    nvec++; if (nv != 1 || ngap != 3) begin nerr++; $display("FAIL %s_count got %0d valids %0d gaps want 1 3", nm, nv, ngap); end
    nvec++; if (g0 !== e0 || g1 !== e1) begin nerr++; $display("FAIL %s_data got %h/%h want %h/%h", nm, g0, g1, e0, e1); end
    nvec++; if (gl !== el) begin nerr++; $display("FAIL %s_lead got %b want %b", nm, gl, el); end
  endtask

  task automatic test_average();
    int s0, s1;
    logic any;
    for (int i = 0; i < 4; i++) begin
      q2a.push_back(16'h0100 + 16'(i));
      q2b.push_back(16'h00FF);
    end
    run_avg(12'h101, 12'h0FF, 1'b0, "avg_dir");
    for (int r = 0; r < 4; r++) begin
      s0 = 0; s1 = 0; any = 1'b0;
      for (int i = 0; i < 4; i++) begin
        logic [11:0] w0, w1;
        logic [3:0] ld;
        w0 = 12'($urandom);
        w1 = 12'($urandom);
        ld = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
        s0 += w0; s1 += w1; any = any | (ld != 0);
        q2a.push_back({ld, w0});
        q2b.push_back({4'h0, w1});
      end
      run_avg(12'(s0 / 4), 12'(s1 / 4), any, "avg_rnd");
    end
  endtask

  task automatic test_lead_err();
    for (int i = 0; i < 4; i++) begin
      q2a.push_back(16'h0200);
      q2b.push_back((i == 2) ? 16'h4123 : 16'h0123);
    end
    run_avg(12'h200, 12'h123, 1'b1, "lead_set");
    for (int i = 0; i < 4; i++) begin
      q2a.push_back(16'h0200);
      q2b.push_back(16'h0123);
    end
    run_avg(12'h200, 12'h123, 1'b0, "lead_clear");
  endtask

  task automatic test_back_to_back();
    int k, nv, falls;
    logic pc;
    logic [11:0] w0, w1;
    q0a.push_back(16'h0ABC);
    q0b.push_back(16'h0123);
    pulse0();
    k = 1; nv = 0; falls = 0; pc = a0.adc_cs_n;
    while (b0 === 1'b1 && k < 400) begin
      @(negedge clk); k++;
      start0 = (k == 20 || k == 132);
      if (v0 === 1'b1) nv++;
      if (pc === 1'b1 && a0.adc_cs_n === 1'b0) falls++;
      pc = a0.adc_cs_n;
    end
    start0 = 1'b0;
    nvec++; if (nv != 1 || falls != 0) begin nerr++; $display("FAIL b2b_ignored got %0d valids %0d extra conv want 1 0", nv, falls); end
    nvec++; if (c0_0 !== 12'hABC || c1_0 !== 12'h123) begin nerr++; $display("FAIL b2b_data got %h/%h want abc/123", c0_0, c1_0); end
    w0 = 12'($urandom); w1 = 12'($urandom);
    q0a.push_back({4'h0, w0});
    q0b.push_back({4'h0, w1});
    pulse0();
    k = 0;
    while (v0 !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    nvec++; if (k >= 400 || c0_0 !== w0 || c1_0 !== w1) begin nerr++; $display("FAIL b2b_restart got %h/%h after %0d want %h/%h", c0_0, c1_0, k, w0, w1); end
    while (b0 !== 1'b0 && k < 400) begin @(negedge clk); k++; end
  endtask

  task automatic test_reset_mid();
    int k, nv;
    logic [11:0] w0, w1;
    q0a.push_back(16'h0555);
    q0b.push_back(16'h0AAA);
    pulse0();
    k = 1;
    while (k < 42) begin @(negedge clk); k++; end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nvec++; if (a0.adc_cs_n !== 1'b1 || a0.adc_sclk !== 1'b1) begin nerr++; $display("FAIL rmid_bus got cs_n %b sclk %b want 1 1", a0.adc_cs_n, a0.adc_sclk); end
    nvec++; if (b0 !== 1'b0 || v0 !== 1'b0) begin nerr++; $display("FAIL rmid_flags got busy %b valid %b want 0 0", b0, v0); end
    nv = 0;
    repeat (200) begin @(negedge clk); if (v0 === 1'b1) nv++; end
    nvec++; if (nv != 0 || c0_0 !== 12'h0) begin nerr++; $display("FAIL rmid_discard got %0d valids ch0 %h want 0 0", nv, c0_0); end
    w0 = 12'($urandom); w1 = 12'($urandom);
    q0a.push_back({4'h0, w0});
    q0b.push_back({4'h0, w1});
    pulse0();
    k = 1;
    while (v0 !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    nvec++; if (k != 129 || c0_0 !== w0 || c1_0 !== w1) begin nerr++; $display("FAIL rmid_fresh got %h/%h at %0d want %h/%h at 129", c0_0, c1_0, k, w0, w1); end
    while (b0 !== 1'b0 && k < 400) begin @(negedge clk); k++; end
  endtask

  task automatic test_free_run();
    int k;
    logic [11:0] w0, w1;
    w0 = 12'($urandom); w1 = 12'($urandom);
    wfa = {4'h0, w0};
    wfb = {4'h0, w1};
    for (int n = 0; n < 2; n++) begin
      k = 0;
      do begin @(negedge clk); k++; end while (vf !== 1'b1 && k < 400);
    end
    for (int n = 0; n < 3; n++) begin
      k = 0;
      do begin
        @(negedge clk); k++;
        startf = 1'($urandom);
      end while (vf !== 1'b1 && k < 400);
      nvec++; if (k != 136) begin nerr++; $display("FAIL free_period got %0d want 136", k); end
      nvec++; if (c0_f !== w0 || c1_f !== w1 || lf !== 1'b0) begin nerr++; $display("FAIL free_data got %h/%h/%b want %h/%h/0", c0_f, c1_f, lf, w0, w1); end
    end
    startf = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_random_single();
    test_average();
    test_lead_err();
    test_back_to_back();
    test_reset_mid();
    test_free_run();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
